pipe_hazard_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage 8-bit pipeline (F, D, E, M, WB). It generates the enables and flushes for the F/D, D/E, E/M and M/WB pipeline latches, and the operand-forwarding selects for stage E. It resolves load-use stalls, taken-branch flushes, the multi-cycle RET drain, external memory-wait freezes and HALT. Its outputs drive every pipeline latch and the E-stage operand muxes.

---
 rtl/pipe_hazard_ctrl_if.sv | 69 ++++++
 rtl/pipe_hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundles every hazard-controller signal between the 5-stage pipeline
// datapath and pipe_hazard_ctrl. Clock and reset are not part of the bundle.
//
//   master modport : pipeline side, drives the register addresses, the
//                    write/use flags and the event strobes, and receives
//                    the latch enables, flushes, forwarding selects and
//                    the controller state.
//   slave modport  : controller side, the mirror image of master.
//
// Signal summary (D/E/M/WB suffix names the stage the signal describes):
//   rs_addrD, rt_addrD, rs_useD, rt_useD      operands read by D
//   rs_addrE, rt_addrE                        operands read by E
//   dest_addrE, reg_wrE, mem_readE            producer in E (load detect)
//   dest_addrM, reg_wrM                       producer in M
//   dest_addrWB, reg_wrWB                     producer in WB
//   branch_takenE, RET_enM, halt_WB           control-flow events
//   ext_stall                                 data memory wait
//   en_F, en_D, en_E, en_M                    latch load enables
//   flush_D, flush_E, flush_M                 latch NOP inserts
//   fwdA_s, fwdB_s                            E operand source selects
//   state                                     00 RUN, 01 RET_DRAIN, 10 HALTED
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;
  logic [1:0] rs_addrD;
  logic [1:0] rt_addrD;
  logic       rs_useD;
  logic       rt_useD;
  logic [1:0] rs_addrE;
  logic [1:0] rt_addrE;
  logic [1:0] dest_addrE;
  logic       reg_wrE;
  logic       mem_readE;
  logic [1:0] dest_addrM;
  logic       reg_wrM;
  logic [1:0] dest_addrWB;
  logic       reg_wrWB;
  logic       branch_takenE;
  logic       RET_enM;
  logic       halt_WB;
  logic       ext_stall;
  logic       en_F;
  logic       en_D;
  logic       en_E;
  logic       en_M;
  logic       flush_D;
  logic       flush_E;
  logic       flush_M;
  logic [1:0] fwdA_s;
  logic [1:0] fwdB_s;
  logic [1:0] state;

  modport master (
    output rs_addrD, rt_addrD, rs_useD, rt_useD, rs_addrE, rt_addrE,
           dest_addrE, reg_wrE, mem_readE, dest_addrM, reg_wrM,
           dest_addrWB, reg_wrWB, branch_takenE, RET_enM, halt_WB, ext_stall,
    input  en_F, en_D, en_E, en_M, flush_D, flush_E, flush_M,
           fwdA_s, fwdB_s, state
  );

  modport slave (
    input  rs_addrD, rt_addrD, rs_useD, rt_useD, rs_addrE, rt_addrE,
           dest_addrE, reg_wrE, mem_readE, dest_addrM, reg_wrM,
           dest_addrWB, reg_wrWB, branch_takenE, RET_enM, halt_WB, ext_stall,
    output en_F, en_D, en_E, en_M, flush_D, flush_E, flush_M,
           fwdA_s, fwdB_s, state
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard and sequencing controller for the F/D/E/M/WB 8-bit pipeline.
// Produces the enables and NOP-flushes of the F-D, D-E, E-M and M-WB latches
// and the E-stage operand forwarding selects. Handles load-use stalls,
// taken-branch flushes, the RET drain, external memory waits and HALT.
//
// Parameters:
//   RET_PENALTY : bubble cycles after a RET resolves in M (1..15)
//   CNT_W       : width of the RET drain counter
//
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset
//   hz    : pipe_hazard_ctrl_if.slave, all pipeline-facing signals
//
// Only the FSM state and the drain counter are registered; every output is
// combinational from them and the current inputs.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int RET_PENALTY = 2,
  parameter int CNT_W       = 4
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    RET_DRAIN = 2'b01,
    HALTED    = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic   [CNT_W-1:0] cnt_q, cnt_d;
  logic               loadUse;

  // State register. Reset returns to RUN with an empty drain counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Forwarding selects. M holds the younger result, so it is checked before
  // WB. Forwarding stays live in every state so held instructions in E keep
  // seeing correct operands; only reset forces the register-file path.
  always_comb begin
    hz.fwdA_s = 2'b00;
    hz.fwdB_s = 2'b00;
    if (rst_n) begin
      if (hz.reg_wrM && hz.dest_addrM == hz.rs_addrE)
        hz.fwdA_s = 2'b01;
      else if (hz.reg_wrWB && hz.dest_addrWB == hz.rs_addrE)
        hz.fwdA_s = 2'b10;
      if (hz.reg_wrM && hz.dest_addrM == hz.rt_addrE)
        hz.fwdB_s = 2'b01;
      else if (hz.reg_wrWB && hz.dest_addrWB == hz.rt_addrE)
        hz.fwdB_s = 2'b10;
    end
  end

  // Next-state and latch-control decode, written as a strict priority chain.
  // A load in E whose result D needs cannot be forwarded in time, so D and F
  // hold for one cycle while a bubble enters E. During ext_stall everything
  // freezes, including pending halt/RET/branch strobes, which are replayed by
  // the held latches once the wait drops.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hz.en_F    = 1'b1;
    hz.en_D    = 1'b1;
    hz.en_E    = 1'b1;
    hz.en_M    = 1'b1;
    hz.flush_D = 1'b0;
    hz.flush_E = 1'b0;
    hz.flush_M = 1'b0;

    loadUse = hz.mem_readE && hz.reg_wrE &&
              ((hz.rs_useD && hz.rs_addrD == hz.dest_addrE) ||
               (hz.rt_useD && hz.rt_addrD == hz.dest_addrE));

    if (!rst_n) begin
      {hz.en_F, hz.en_D, hz.en_E, hz.en_M} = 4'b0000;
      {hz.flush_D, hz.flush_E, hz.flush_M} = 3'b111;
    end else if (hz.ext_stall || state_q == HALTED) begin
      {hz.en_F, hz.en_D, hz.en_E, hz.en_M} = 4'b0000;
    end else if (hz.halt_WB) begin
      {hz.en_F, hz.en_D, hz.en_E, hz.en_M} = 4'b0000;
      state_d = HALTED;
    end else if (state_q == RUN && hz.RET_enM) begin
      hz.en_F = 1'b0;
      {hz.flush_D, hz.flush_E, hz.flush_M} = 3'b111;
      state_d = RET_DRAIN;
      cnt_d   = CNT_W'(RET_PENALTY);
    end else if (state_q == RET_DRAIN) begin
      // E only holds bubbles here, so branch and load-use are irrelevant.
      // The <= 1 test also recovers if an illegal zero penalty is configured.
      hz.en_F    = 1'b0;
      hz.flush_D = 1'b1;
      cnt_d      = cnt_q - CNT_W'(1);
      if (cnt_q <= CNT_W'(1))
        state_d = RUN;
    end else if (hz.branch_takenE) begin
      hz.flush_D = 1'b1;
      hz.flush_E = 1'b1;
    end else if (loadUse) begin
      hz.en_F    = 1'b0;
      hz.en_D    = 1'b0;
      hz.flush_E = 1'b1;
    end
  end

  assign hz.state = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Self-checking bench for pipe_hazard_ctrl with RET_PENALTY=2. Directed
// scenario tasks followed by a randomized run against a behavioural model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int PENALTY = 2;

  logic clk;
  logic rst_n;
  int   checkCount;
  int   passCount;

  pipe_hazard_ctrl_if hz ();

  pipe_hazard_ctrl #(.RET_PENALTY(PENALTY), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Latch controls gathered as {en_F,en_D,en_E,en_M,flush_D,flush_E,flush_M}.
  logic [6:0] obsVec;
  assign obsVec = {hz.en_F, hz.en_D, hz.en_E, hz.en_M,
                   hz.flush_D, hz.flush_E, hz.flush_M};

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Park every pipeline-facing input at an idle, hazard-free value.
  task automatic clearInputs();
    hz.rs_addrD = 2'd0; hz.rt_addrD = 2'd0; hz.rs_useD = 1'b0; hz.rt_useD = 1'b0;
    hz.rs_addrE = 2'd0; hz.rt_addrE = 2'd0;
    hz.dest_addrE = 2'd0; hz.reg_wrE = 1'b0; hz.mem_readE = 1'b0;
    hz.dest_addrM = 2'd0; hz.reg_wrM = 1'b0;
    hz.dest_addrWB = 2'd0; hz.reg_wrWB = 1'b0;
    hz.branch_takenE = 1'b0; hz.RET_enM = 1'b0; hz.halt_WB = 1'b0;
    hz.ext_stall = 1'b0;
  endtask

  // Reset held two cycles forces idle latches even with forwarding matches
  // present; the first cycle after release is a normal RUN cycle.
  task automatic test_reset();
    clearInputs();
    rst_n = 1'b0;
    hz.reg_wrM = 1'b1; hz.dest_addrM = 2'd0; hz.rs_addrE = 2'd0;
    @(negedge clk);
    checkCount++;
    if (obsVec !== 7'b0000111) $display("[TB] FAIL reset_ctl0: got %b, expected %b", obsVec, 7'b0000111);
    else passCount++;
    checkCount++;
    if (hz.fwdA_s !== 2'b00) $display("[TB] FAIL reset_fwdA: got %b, expected %b", hz.fwdA_s, 2'b00);
    else passCount++;
    nextCycle();
    @(negedge clk);
    checkCount++;
    if (obsVec !== 7'b0000111) $display("[TB] FAIL reset_ctl1: got %b, expected %b", obsVec, 7'b0000111);
    else passCount++;
    nextCycle();
    rst_n = 1'b1;
    clearInputs();
    @(negedge clk);
    checkCount++;
    if (hz.state !== 2'b00) $display("[TB] FAIL reset_state: got %b, expected %b", hz.state, 2'b00);
    else passCount++;
    checkCount++;
    if (obsVec !== 7'b1111000) $display("[TB] FAIL reset_release: got %b, expected %b", obsVec, 7'b1111000);
    else passCount++;
  endtask

  // One-cycle load-use stall, then M forwarding supplies the loaded value.
  task automatic test_load_use();
    nextCycle();
    clearInputs();
    hz.mem_readE = 1'b1; hz.reg_wrE = 1'b1; hz.dest_addrE = 2'd2;
    hz.rs_addrD = 2'd2; hz.rs_useD = 1'b1;
    @(negedge clk);
    checkCount++;
    if (obsVec !== 7'b0011010) $display("[TB] FAIL loaduse_stall: got %b, expected %b", obsVec, 7'b0011010);
    else passCount++;
    nextCycle();
    clearInputs();
    hz.rs_addrE = 2'd2; hz.reg_wrM = 1'b1; hz.dest_addrM = 2'd2;
    @(negedge clk);
    checkCount++;
    if (hz.fwdA_s !== 2'b01) $display("[TB] FAIL loaduse_fwdA: got %b, expected %b", hz.fwdA_s, 2'b01);
    else passCount++;
    checkCount++;
    if (obsVec !== 7'b1111000) $display("[TB] FAIL loaduse_resume: got %b, expected %b", obsVec, 7'b1111000);
    else passCount++;
    // A matching address on an operand D does not read is not a hazard.
    nextCycle();
    clearInputs();
    hz.mem_readE = 1'b1; hz.reg_wrE = 1'b1; hz.dest_addrE = 2'd3;
    hz.rt_addrD = 2'd3; hz.rt_useD = 1'b0; hz.rs_useD = 1'b1; hz.rs_addrD = 2'd1;
    @(negedge clk);
    checkCount++;
    if (obsVec !== 7'b1111000) $display("[TB] FAIL loaduse_unused: got %b, expected %b", obsVec, 7'b1111000);
    else passCount++;
  endtask

  // M beats WB; WB used when M does not write; every register forwardable.
  task automatic test_forward_priority();
    nextCycle();
    clearInputs();
    hz.dest_addrM = 2'd1; hz.dest_addrWB = 2'd1;
    hz.reg_wrM = 1'b1; hz.reg_wrWB = 1'b1; hz.rt_addrE = 2'd1;
    @(negedge clk);
    checkCount++;
    if (hz.fwdB_s !== 2'b01) $display("[TB] FAIL fwd_m_over_wb: got %b, expected %b", hz.fwdB_s, 2'b01);
    else passCount++;
    nextCycle();
    hz.reg_wrM = 1'b0;
    @(negedge clk);
    checkCount++;
    if (hz.fwdB_s !== 2'b10) $display("[TB] FAIL fwd_wb_only: got %b, expected %b", hz.fwdB_s, 2'b10);
    else passCount++;
    for (int r = 0; r < 4; r++) begin
      nextCycle();
      clearInputs();
      hz.rs_addrE = 2'(r); hz.dest_addrWB = 2'(r); hz.reg_wrWB = 1'b1;
      hz.rt_addrE = 2'(r + 1); hz.dest_addrM = 2'(r + 1); hz.reg_wrM = 1'b1;
      @(negedge clk);
      checkCount++;
      if ({hz.fwdA_s, hz.fwdB_s} !== 4'b1001)
        $display("[TB] FAIL fwd_reg%0d: got %b, expected %b", r, {hz.fwdA_s, hz.fwdB_s}, 4'b1001);
      else passCount++;
    end
  endtask

  // Branch and load-use together: branch flush wins, nothing stalls.
  task automatic test_branch_load_use();
    nextCycle();
    clearInputs();
    hz.branch_takenE = 1'b1;
    hz.mem_readE = 1'b1; hz.reg_wrE = 1'b1; hz.dest_addrE = 2'd1;
    hz.rt_addrD = 2'd1; hz.rt_useD = 1'b1;
    @(negedge clk);
    checkCount++;
    if (obsVec !== 7'b1111110) $display("[TB] FAIL branch_lu: got %b, expected %b", obsVec, 7'b1111110);
    else passCount++;
    nextCycle();
    clearInputs();
    @(negedge clk);
    checkCount++;
    if (obsVec !== 7'b1111000) $display("[TB] FAIL branch_after: got %b, expected %b", obsVec, 7'b1111000);
    else passCount++;
  endtask

  // RET drain: fetch blocked PENALTY+1 cycles, then again with a 2-cycle
  // memory wait in the middle that must stretch the drain.
  task automatic test_ret_drain();
    logic [6:0] expVec [5];
    logic [1:0] expSt  [5];
    expVec = '{7'b0111111, 7'b0111100, 7'b0111100, 7'b1111000, 7'b1111000};
    expSt  = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    for (int c = 0; c < 5; c++) begin
      nextCycle();
      clearInputs();
      hz.RET_enM = (c == 0);
      hz.branch_takenE = (c == 1);
      @(negedge clk);
      checkCount++;
      if ({obsVec, hz.state} !== {expVec[c], expSt[c]})
        $display("[TB] FAIL ret_c%0d: got %b/%b, expected %b/%b", c, obsVec, hz.state, expVec[c], expSt[c]);
      else passCount++;
    end
    expVec = '{7'b0111111, 7'b0111100, 7'b0000000, 7'b0000000, 7'b0111100};
    expSt  = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01};
    for (int c = 0; c < 5; c++) begin
      nextCycle();
      clearInputs();
      hz.RET_enM = (c == 0);
      hz.ext_stall = (c == 2 || c == 3);
      @(negedge clk);
      checkCount++;
      if ({obsVec, hz.state} !== {expVec[c], expSt[c]})
        $display("[TB] FAIL ret_stall_c%0d: got %b/%b, expected %b/%b", c, obsVec, hz.state, expVec[c], expSt[c]);
      else passCount++;
    end
    nextCycle();
    clearInputs();
    @(negedge clk);
    checkCount++;
    if ({obsVec, hz.state} !== {7'b1111000, 2'b00})
      $display("[TB] FAIL ret_stall_end: got %b/%b, expected %b/%b", obsVec, hz.state, 7'b1111000, 2'b00);
    else passCount++;
  endtask

  // HALT is held off by ext_stall, then sticks until reset.
  task automatic test_halt();
    nextCycle();
    clearInputs();
    hz.halt_WB = 1'b1; hz.ext_stall = 1'b1;
    @(negedge clk);
    checkCount++;
    if ({obsVec, hz.state} !== {7'b0000000, 2'b00})
      $display("[TB] FAIL halt_stalled: got %b/%b, expected %b/%b", obsVec, hz.state, 7'b0000000, 2'b00);
    else passCount++;
    nextCycle();
    hz.ext_stall = 1'b0;
    @(negedge clk);
    checkCount++;
    if ({obsVec, hz.state} !== {7'b0000000, 2'b00})
      $display("[TB] FAIL halt_accept: got %b/%b, expected %b/%b", obsVec, hz.state, 7'b0000000, 2'b00);
    else passCount++;
    for (int c = 0; c < 3; c++) begin
      nextCycle();
      clearInputs();
      hz.RET_enM = (c == 0); hz.branch_takenE = (c == 1);
      hz.reg_wrWB = 1'b1; hz.dest_addrWB = 2'd3; hz.rs_addrE = 2'd3;
      @(negedge clk);
      checkCount++;
      if ({obsVec, hz.state, hz.fwdA_s} !== {7'b0000000, 2'b10, 2'b10})
        $display("[TB] FAIL halted_c%0d: got %b/%b/%b, expected %b/%b/%b", c, obsVec, hz.state, hz.fwdA_s,
                 7'b0000000, 2'b10, 2'b10);
      else passCount++;
    end
    nextCycle();
    clearInputs();
    rst_n = 1'b0;
    @(negedge clk);
    checkCount++;
    if (obsVec !== 7'b0000111) $display("[TB] FAIL halt_reset: got %b, expected %b", obsVec, 7'b0000111);
    else passCount++;
    nextCycle();
    rst_n = 1'b1;
    @(negedge clk);
    checkCount++;
    if ({obsVec, hz.state} !== {7'b1111000, 2'b00})
      $display("[TB] FAIL halt_exit: got %b/%b, expected %b/%b", obsVec, hz.state, 7'b1111000, 2'b00);
    else passCount++;
  endtask

  // Randomized traffic against a behavioural model. The model keeps a mode
  // (0 run, 1 draining, 2 halted) and the number of drain cycles still owed,
  // and derives each cycle's latch controls from the event priority order.
  task automatic test_random();
    int         mode;
    int         drainLeft;
    logic [6:0] expVec;
    logic [1:0] expFwd [2];
    logic [1:0] srcs   [2];
    logic [1:0] prodDst [2];
    logic       prodWr  [2];
    logic [1:0] prodSel [2];
    logic [1:0] useAddr [2];
    logic       useFlag [2];
    bit         hazard;
    mode = 0;
    drainLeft = 0;
    for (int n = 0; n < 800; n++) begin
      nextCycle();
      rst_n            = ($urandom_range(99) >= 3);
      hz.ext_stall     = ($urandom_range(99) < 15);
      hz.halt_WB       = ($urandom_range(99) < 2);
      hz.RET_enM       = ($urandom_range(99) < 6);
      hz.branch_takenE = ($urandom_range(99) < 20);
      hz.mem_readE     = ($urandom_range(99) < 40);
      hz.reg_wrE = 1'($urandom); hz.reg_wrM = 1'($urandom); hz.reg_wrWB = 1'($urandom);
      hz.rs_useD = 1'($urandom); hz.rt_useD = 1'($urandom);
      hz.rs_addrD = 2'($urandom); hz.rt_addrD = 2'($urandom);
      hz.rs_addrE = 2'($urandom); hz.rt_addrE = 2'($urandom);
      hz.dest_addrE = 2'($urandom); hz.dest_addrM = 2'($urandom); hz.dest_addrWB = 2'($urandom);

      // Load-use: some operand D actually reads is the register the load in E
      // is about to produce.
      useAddr = '{hz.rs_addrD, hz.rt_addrD};
      useFlag = '{hz.rs_useD, hz.rt_useD};
      hazard = 1'b0;
      for (int k = 0; k < 2; k++)
        if (hz.mem_readE && hz.reg_wrE && useFlag[k] && useAddr[k] == hz.dest_addrE) hazard = 1'b1;

      if (!rst_n)                        expVec = 7'b0000111;
      else if (hz.ext_stall)             expVec = 7'b0000000;
      else if (mode == 2)                expVec = 7'b0000000;
      else if (hz.halt_WB)               expVec = 7'b0000000;
      else if (mode == 0 && hz.RET_enM)  expVec = 7'b0111111;
      else if (mode == 1)                expVec = 7'b0111100;
      else if (hz.branch_takenE)         expVec = 7'b1111110;
      else if (hazard)                   expVec = 7'b0011010;
      else                               expVec = 7'b1111000;

      // Forwarding: youngest writing producer (M, then WB) that matches.
      srcs    = '{hz.rs_addrE, hz.rt_addrE};
      prodDst = '{hz.dest_addrM, hz.dest_addrWB};
      prodWr  = '{hz.reg_wrM, hz.reg_wrWB};
      prodSel = '{2'b01, 2'b10};
      for (int s = 0; s < 2; s++) begin
        expFwd[s] = 2'b00;
        if (rst_n)
          for (int p = 1; p >= 0; p--)
            if (prodWr[p] && prodDst[p] == srcs[s]) expFwd[s] = prodSel[p];
      end

      @(negedge clk);
      checkCount++;
      if (obsVec !== expVec) $display("[TB] FAIL rand_ctl@%0d: got %b, expected %b", n, obsVec, expVec);
      else passCount++;
      checkCount++;
      if (hz.fwdA_s !== expFwd[0]) $display("[TB] FAIL rand_fwdA@%0d: got %b, expected %b", n, hz.fwdA_s, expFwd[0]);
      else passCount++;
      checkCount++;
      if (hz.fwdB_s !== expFwd[1]) $display("[TB] FAIL rand_fwdB@%0d: got %b, expected %b", n, hz.fwdB_s, expFwd[1]);
      else passCount++;
      checkCount++;
      if (hz.state !== 2'(mode)) $display("[TB] FAIL rand_state@%0d: got %b, expected %b", n, hz.state, 2'(mode));
      else passCount++;

      if (!rst_n) begin
        mode = 0; drainLeft = 0;
      end else if (!hz.ext_stall && mode != 2) begin
        if (hz.halt_WB) mode = 2;
        else if (mode == 0 && hz.RET_enM) begin
          mode = 1; drainLeft = PENALTY;
        end else if (mode == 1) begin
          drainLeft = drainLeft - 1;
          if (drainLeft == 0) mode = 0;
        end
      end
    end
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst_n      = 1'b0;
    clearInputs();
    test_reset();
    test_load_use();
    test_forward_priority();
    test_branch_load_use();
    test_ret_drain();
    test_halt();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
